sequenciador_envase: RTL
========================

// Module: sequenciador_envase
// PURPOSE
//  Top-level sequencer for one bottling station: conveyor, fill valve, capper and bottle/dozen counting.
//  Sits above the dozen counter: drives the conveyor/valve/capper and pulses one bottle per completed cycle.
//  Keeps the per-box bottle count and the total dozens produced.
// PARAMETERS
//  SEAL_CYCLES      8    cycles the capper is held active per bottle (>=1)
//  FILL_TIMEOUT     255  max FILL cycles before alarm (used only with ENVASE_TIMEOUT_EN)
//  BOTTLES_PER_BOX  12   bottles per box; bottle count wraps here
//  DOZEN_W          7    width of dozen_count
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low; 0 = reset
//  start         in   1        level; begin/resume production from IDLE
//  stop          in   1        level; request stop at next bottle boundary
//  bottle_sense  in   1        bottle present under the filler
//  level_ok      in   1        fill level reached
//  alarm_clr     in   1        operator acknowledge; leaves ALARM
//  motor_on      out  1        conveyor enable
//  valve_on      out  1        fill valve enable
//  seal_on       out  1        capper enable
//  bottle_pulse  out  1        1-cycle pulse per finished bottle
//  dozen_pulse   out  1        1-cycle pulse when a box completes
//  bottle_count  out  4        bottles in current box, 0..BOTTLES_PER_BOX-1
//  dozen_count   out  DOZEN_W  completed boxes; saturates at all-ones
//  alarm         out  1        fill timeout flag
// BEHAVIOUR
//  - Reset (reset=0, any state): state IDLE; all outputs 0; counters, timer and stop_req cleared at once.
//  - Moore FSM; outputs decode only the state register, so they change one clk after the sampled input.
//  - IDLE:   all enables 0; start=1 -> MOVE.
//  - MOVE:   motor_on=1; stop=1 -> IDLE (stop wins over bottle_sense); else bottle_sense=1 -> FILL.
//  - FILL:   valve_on=1; level_ok=1 -> SEAL; timer counts cycles spent in FILL.
//  - SEAL:   seal_on=1 for exactly SEAL_CYCLES cycles, then -> COUNT.
//  - COUNT:  one cycle; bottle_pulse=1; bottle_count+1.
//            If bottle_count==BOTTLES_PER_BOX-1: bottle_count->0, dozen_pulse=1 in the same cycle,
//            dozen_count+1 (saturating, no wrap).
//            Next state: stop_req ? IDLE : MOVE. stop_req is cleared on leaving COUNT.
//  - stop asserted during FILL/SEAL/COUNT sets stop_req; a bottle in progress always completes.
//  - start is ignored outside IDLE. alarm_clr is ignored outside ALARM.
//  - Minimum bottle cycle: MOVE(1)+FILL(1)+SEAL(SEAL_CYCLES)+COUNT(1) clk.
//  - Counters change only in COUNT; counts survive IDLE and ALARM; only reset clears them.
// CONFIGURATION
//  ENVASE_TIMEOUT_EN defined:
//   - If FILL lasts FILL_TIMEOUT cycles with level_ok=0 -> ALARM.
//   - level_ok=1 in the timeout cycle has priority and goes to SEAL.
//   - ALARM: alarm=1, all enables 0; alarm_clr=1 -> IDLE.
//   - The aborted bottle is not counted; stop_req is cleared.
//  ENVASE_TIMEOUT_EN undefined:
//   - FILL waits indefinitely; ALARM state, alarm timer and FILL_TIMEOUT are absent.
//   - alarm is tied 0; alarm_clr is unused.
// STRUCTURE
//  - Shared package envase_pkg holds the 3-bit state encoding:
//    IDLE=0, MOVE=1, FILL=2, SEAL=3, COUNT=4, ALARM=5; 6..7 return to IDLE.
//    It also holds the default BOTTLES_PER_BOX constant shared with the dozen counter.
//  - Sub-module temporizador_envase: loadable down-counter with a zero flag.
//    Instantiated once for the SEAL duration and once, under the macro, for the FILL timeout.
// TESTING
//  1. reset=0 mid-SEAL -> next sample: all outputs 0, IDLE, counts 0; after release, start=1 -> motor_on=1 next clk.
//  2. 12 bottle cycles (bottle_sense, level_ok after 3 clk), SEAL_CYCLES=8:
//     seal_on high exactly 8 clk each; 12 bottle_pulse; dozen_pulse with the 12th; bottle_count=0; dozen_count=1.
//  3. stop=1 in FILL -> bottle completes, bottle_pulse=1, then IDLE, motor_on stays 0.
//     stop=1 and bottle_sense=1 in MOVE -> IDLE.
//  4. ENVASE_TIMEOUT_EN, FILL_TIMEOUT=16, level_ok=0: alarm=1 after 16 FILL clk, valve_on=0, counts unchanged.
//     alarm_clr -> IDLE.
//  5. DOZEN_W=2, 48 bottles -> dozen_count saturates at 3; the 4th dozen_pulse still fires.
//  6. level_ok=1 in the cycle FILL is entered -> SEAL next clk; FILL lasts exactly 1 clk.

Source files
------------

// File: rtl/envase_pkg.sv
// Shared definitions for the bottling station: FSM state encoding and the
// default box size used by the sequencer and the dozen counter.
package envase_pkg;

  // 3-bit state code; codes 6..7 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_SEAL  = 3'd3,
    ST_COUNT = 3'd4,
    ST_ALARM = 3'd5
  } state_e;

  localparam int BOTTLES_PER_BOX_DEF = 12;
  localparam int BOTTLE_CNT_W        = 4;

endpackage

// File: rtl/temporizador_envase.sv
// Loadable down-counter with a zero flag. load has priority over en; the
// count stops at zero instead of wrapping.
module temporizador_envase #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Next count: reload, decrement while enabled, or hold.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && (count_q != '0))
      count_d = count_q - W'(1);
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sequenciador_envase.sv
// Bottling-station sequencer: conveyor, fill valve, capper and bottle/dozen
// counting. Optional fill timeout and ALARM state are enabled by defining
// ENVASE_TIMEOUT_EN; without it FILL waits indefinitely and alarm is tied 0.
// Handshake: none; start/stop are levels sampled on every rising clk edge.
module sequenciador_envase
  import envase_pkg::*;
#(
  parameter int SEAL_CYCLES     = 8,
  parameter int FILL_TIMEOUT    = 255,
  parameter int BOTTLES_PER_BOX = BOTTLES_PER_BOX_DEF,
  parameter int DOZEN_W         = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    bottle_sense,
  input  logic                    level_ok,
  input  logic                    alarm_clr,
  output logic                    motor_on,
  output logic                    valve_on,
  output logic                    seal_on,
  output logic                    bottle_pulse,
  output logic                    dozen_pulse,
  output logic [BOTTLE_CNT_W-1:0] bottle_count,
  output logic [DOZEN_W-1:0]      dozen_count,
  output logic                    alarm,
  output state_e                  state_dbg
);

  localparam int SEAL_W = $clog2(SEAL_CYCLES + 1);

  state_e                  state_q, state_d;
  logic                    stop_req_q, stop_req_d;
  logic [BOTTLE_CNT_W-1:0] bottle_count_q, bottle_count_d;
  logic [DOZEN_W-1:0]      dozen_count_q, dozen_count_d;
  logic                    motor_on_q, valve_on_q, seal_on_q;
  logic                    bottle_pulse_q, dozen_pulse_q;
  logic                    box_full;
  logic                    seal_zero;
  logic                    fill_zero;

  assign box_full = (bottle_count_q == BOTTLE_CNT_W'(BOTTLES_PER_BOX - 1));

  // Capper duration: loaded with SEAL_CYCLES-1 on entry, so SEAL lasts
  // exactly SEAL_CYCLES clocks before the zero flag releases it.
  temporizador_envase #(.W(SEAL_W)) u_seal_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q != ST_SEAL) && (state_d == ST_SEAL)),
    .load_val (SEAL_W'(SEAL_CYCLES - 1)),
    .en       (state_q == ST_SEAL),
    .zero     (seal_zero)
  );

`ifdef ENVASE_TIMEOUT_EN
  localparam int FILL_W = $clog2(FILL_TIMEOUT + 1);
  logic alarm_q;

  // Fill watchdog: reaches zero in the FILL_TIMEOUT-th cycle of FILL.
  temporizador_envase #(.W(FILL_W)) u_fill_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q != ST_FILL) && (state_d == ST_FILL)),
    .load_val (FILL_W'(FILL_TIMEOUT - 1)),
    .en       (state_q == ST_FILL),
    .zero     (fill_zero)
  );
  assign alarm = alarm_q;
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
  assign fill_zero        = 1'b0;
  assign alarm            = 1'b0;
`endif

  // Next-state, stop request and counter updates (counters move only in COUNT).
  always_comb begin
    state_d        = state_q;
    stop_req_d     = stop_req_q;
    bottle_count_d = bottle_count_q;
    dozen_count_d  = dozen_count_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MOVE;
      ST_MOVE: begin
        if (stop)              state_d = ST_IDLE;
        else if (bottle_sense) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (stop) stop_req_d = 1'b1;
        if (level_ok) begin
          state_d = ST_SEAL;
        end else if (fill_zero) begin
          state_d    = ST_ALARM;
          stop_req_d = 1'b0;
        end
      end
      ST_SEAL: begin
        if (stop)      stop_req_d = 1'b1;
        if (seal_zero) state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        bottle_count_d = box_full ? '0 : bottle_count_q + BOTTLE_CNT_W'(1);
        if (box_full && (dozen_count_q != {DOZEN_W{1'b1}}))
          dozen_count_d = dozen_count_q + DOZEN_W'(1);
        // A stop arriving in COUNT itself also ends the run here.
        state_d    = (stop_req_q || stop) ? ST_IDLE : ST_MOVE;
        stop_req_d = 1'b0;
      end
`ifdef ENVASE_TIMEOUT_EN
      ST_ALARM: if (alarm_clr) state_d = ST_IDLE;
`else
      ST_ALARM: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      stop_req_q     <= 1'b0;
      bottle_count_q <= '0;
      dozen_count_q  <= '0;
      motor_on_q     <= 1'b0;
      valve_on_q     <= 1'b0;
      seal_on_q      <= 1'b0;
      bottle_pulse_q <= 1'b0;
      dozen_pulse_q  <= 1'b0;
`ifdef ENVASE_TIMEOUT_EN
      alarm_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      stop_req_q     <= stop_req_d;
      bottle_count_q <= bottle_count_d;
      dozen_count_q  <= dozen_count_d;
      motor_on_q     <= (state_d == ST_MOVE);
      valve_on_q     <= (state_d == ST_FILL);
      seal_on_q      <= (state_d == ST_SEAL);
      bottle_pulse_q <= (state_d == ST_COUNT);
      dozen_pulse_q  <= (state_d == ST_COUNT) && box_full;
`ifdef ENVASE_TIMEOUT_EN
      alarm_q        <= (state_d == ST_ALARM);
`endif
    end
  end

  assign motor_on     = motor_on_q;
  assign valve_on     = valve_on_q;
  assign seal_on      = seal_on_q;
  assign bottle_pulse = bottle_pulse_q;
  assign dozen_pulse  = dozen_pulse_q;
  assign bottle_count = bottle_count_q;
  assign dozen_count  = dozen_count_q;
  assign state_dbg    = state_q;

endmodule
